// File: rtl/minmcu_uart_pkg.sv
// Shared UART definitions for the MCU serial link: receiver state encoding,
// data width and the default bit period used by both the receiver and transmitter.
package minmcu_uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 87;   // 10 MHz / 115200 baud

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    // Even-parity bit: makes the total number of ones (data + parity) even.
    function automatic logic uart_even_parity(input logic [UART_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// Receive-side consumer handshake of the UART receiver: head byte with valid/ready
// plus single-cycle error pulses. master = receiver, slave = consumer.
interface uart_rx_buffered_if;
    import minmcu_uart_pkg::*;

    logic [UART_DATA_W-1:0] rx_data_o;
    logic                   rx_valid_o;
    logic                   rx_ready_i;
    logic                   frame_err_o;
    logic                   overrun_o;
    logic                   parity_err_o;

    modport master (
        output rx_data_o,
        output rx_valid_o,
        input  rx_ready_i,
        output frame_err_o,
        output overrun_o,
        output parity_err_o
    );

    modport slave (
        input  rx_data_o,
        input  rx_valid_o,
        output rx_ready_i,
        input  frame_err_o,
        input  overrun_o,
        input  parity_err_o
    );

endinterface

// File: rtl/uart_rx_buffered_fifo.sv
// Flop-based receive FIFO (module uart_rx_fifo): head is the oldest entry, no
// write-to-read bypass; a push into a full FIFO only lands when a pop frees a slot.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver: synchronizer, mid-bit sampling FSM and receive FIFO.
// Frame is 8N1 by default; define UART_RX_PARITY_EN for 8E1 with parity checking.
//
//   state  | meaning
//   IDLE   | line idle, waiting for a falling edge
//   START  | half-bit wait, confirm start bit still low
//   DATA   | sample 8 data bits LSB first, one per bit period
//   PARITY | sample parity bit (UART_RX_PARITY_EN only)
//   STOP   | sample stop bit, then push byte or flag error
module uart_rx_buffered
    import minmcu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_i,
    uart_rx_buffered_if.master bus
);

    localparam int BAUD_W = 10;
    localparam logic [BAUD_W-1:0] HALF_LOAD = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_LOAD = BAUD_W'(CLKS_PER_BIT - 1);

    logic                   sync1_q;
    logic                   rx_s;
    logic                   rx_prev;
    logic [1:0]             live_q;
    logic                   armed_q;
    logic                   start_det;

    uart_rx_state_t         state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   baud_tc;

    logic                   push_byte;
    logic                   pop_req;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   parity_bad;

`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   parity_err_q, parity_err_d;
`endif

    // live_q marks when rx_s carries a real line sample rather than its reset value;
    // starts are only armed once the line has really been seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b0;
            live_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            rx_s    <= sync1_q;
            rx_prev <= rx_s;
            live_q  <= {live_q[0], 1'b1};
            armed_q <= armed_q | (live_q[1] & rx_s);
        end
    end

    assign start_det = armed_q && rx_prev && !rx_s;
    assign baud_tc   = (baud_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_bad = (par_q != uart_even_parity(shift_q));
`else
    assign parity_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push_byte   = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (start_det) begin
                    state_d = START;
                    bit_d   = '0;
                    baud_d  = HALF_LOAD;
                end
            end
            START: begin
                if (baud_tc) begin
                    baud_d  = FULL_LOAD;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_tc) begin
                    shift_d = {rx_s, shift_q[UART_DATA_W-1:1]};
                    baud_d  = FULL_LOAD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_tc) begin
                    par_d   = rx_s;
                    baud_d  = FULL_LOAD;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
`endif
            STOP: begin
                // Back to IDLE at mid stop bit so a following start edge is not missed.
                if (baud_tc) begin
                    state_d = IDLE;
                    if (parity_bad) begin
`ifdef UART_RX_PARITY_EN
                        parity_err_d = 1'b1;
`endif
                    end else if (!rx_s) begin
                        frame_err_d = 1'b1;
                    end else begin
                        push_byte = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pop_req   = !fifo_empty && bus.rx_ready_i;
    assign overrun_d = push_byte && fifo_full && !pop_req;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_byte),
        .wdata (shift_q),
        .full  (fifo_full),
        .pop   (pop_req),
        .empty (fifo_empty),
        .head  (bus.rx_data_o)
    );

    assign bus.rx_valid_o  = !fifo_empty;
    assign bus.frame_err_o = frame_err_q;
    assign bus.overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err_o = parity_err_q;
`else
    assign bus.parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: expected bytes are queued when frames are
// driven and compared as the consumer pops them; error pulses are counted per cycle.
module tb_uart_rx_buffered;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Start-drive edge to rx_valid_o rise: 2 sync + 1 detect + half bit + remaining bits.
    localparam int LAT = 3 + CPB / 2 + (NBITS - 1) * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx_i  = 1'b1;

    uart_rx_buffered_if bus();

    uart_rx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_i  (rx_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         vectors        = 0;
    int         miscompares    = 0;
    int         cyc            = 0;
    int         frame_err_cnt  = 0;
    int         overrun_cnt    = 0;
    int         parity_err_cnt = 0;
    int         pop_cnt        = 0;
    int         rise_cyc       = -1;
    logic       valid_prev     = 1'b0;
    logic [7:0] exp_q [$];

    always @(posedge clk) cyc++;

    // Consumer-side monitor: pops the scoreboard on every accepted byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_err_o)  frame_err_cnt++;
            if (bus.overrun_o)    overrun_cnt++;
            if (bus.parity_err_o) parity_err_cnt++;
            if (bus.rx_valid_o && !valid_prev) rise_cyc = cyc;
            if (bus.rx_valid_o && bus.rx_ready_i) begin
                logic [7:0] exp_b;
                pop_cnt++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL pop_unexpected: got %02h, required no byte", bus.rx_data_o);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (bus.rx_data_o !== exp_b) begin
                        miscompares++;
                        $display("FAIL pop_data: got %02h, required %02h", bus.rx_data_o, exp_b);
                    end
                end
            end
        end
        valid_prev = bus.rx_valid_o;
    end

    task automatic drive_bit(input logic b);
        rx_i = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
        logic pbit;
        pbit = (^d) ^ bad_par;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(pbit);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic check_int(input string name, input int got, input int req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        bus.rx_ready_i = 1'b1;
        rst_n = 1'b0;
        rx_i  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.rx_valid_o, bus.rx_data_o} !== 9'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b data=%02h, required valid=0 data=00",
                     bus.rx_valid_o, bus.rx_data_o);
        end
        vectors++;
        if ({bus.frame_err_o, bus.overrun_o, bus.parity_err_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_errors: got %b, required 000",
                     {bus.frame_err_o, bus.overrun_o, bus.parity_err_o});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1 rx_i = 1'b1;
        repeat (12 * CPB) @(posedge clk);
        @(negedge clk);
        check_int("held_low_no_frame_pops", pop_cnt, 0);
        check_int("held_low_no_frame_err", frame_err_cnt, 0);
    endtask

    task automatic test_single_byte();
        int p0, start_cyc, err0;
        p0   = pop_cnt;
        err0 = frame_err_cnt + overrun_cnt + parity_err_cnt;
        bus.rx_ready_i = 1'b1;
        exp_q.push_back(8'hA5);
        @(posedge clk); #1;
        start_cyc = cyc;
        rise_cyc  = -1;
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_int("a5_latency", rise_cyc - start_cyc, LAT);
        check_int("a5_pops", pop_cnt - p0, 1);
        check_int("a5_errors", frame_err_cnt + overrun_cnt + parity_err_cnt - err0, 0);
    endtask

    task automatic test_overrun();
        int p0, o0, f0;
        p0 = pop_cnt;
        o0 = overrun_cnt;
        f0 = frame_err_cnt;
        bus.rx_ready_i = 1'b0;
        for (int i = 1; i <= DEPTH; i++) exp_q.push_back(8'(i));
        @(posedge clk); #1;
        for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b1, 1'b0);
        repeat (2 * CPB) @(posedge clk);
        @(negedge clk);
        check_int("overrun_pulses", overrun_cnt - o0, 1);
        check_int("overrun_no_frame_err", frame_err_cnt - f0, 0);
        vectors++;
        if ({bus.rx_valid_o, bus.rx_data_o} !== {1'b1, 8'h01}) begin
            miscompares++;
            $display("FAIL full_head: got valid=%b data=%02h, required valid=1 data=01",
                     bus.rx_valid_o, bus.rx_data_o);
        end
        @(posedge clk); #1;
        bus.rx_ready_i = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_int("drain_pops", pop_cnt - p0, DEPTH);
        check_int("drain_valid", int'(bus.rx_valid_o), 0);
        check_int("drain_queue", exp_q.size(), 0);
    endtask

    task automatic test_glitch();
        int p0, e0;
        p0 = pop_cnt;
        e0 = frame_err_cnt + overrun_cnt + parity_err_cnt;
        bus.rx_ready_i = 1'b1;
        @(posedge clk); #1;
        rx_i = 1'b0;
        repeat (CPB / 4) @(posedge clk);
        #1 rx_i = 1'b1;
        repeat (12 * CPB) @(posedge clk);
        @(negedge clk);
        check_int("glitch_pops", pop_cnt - p0, 0);
        check_int("glitch_errors", frame_err_cnt + overrun_cnt + parity_err_cnt - e0, 0);
        exp_q.push_back(8'h5A);
        @(posedge clk); #1;
        send_frame(8'h5A, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_int("after_glitch_pops", pop_cnt - p0, 1);
    endtask

    task automatic test_frame_error();
        int p0, f0;
        p0 = pop_cnt;
        f0 = frame_err_cnt;
        bus.rx_ready_i = 1'b1;
        @(posedge clk); #1;
        send_frame(8'h3C, 1'b0, 1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        @(negedge clk);
        check_int("frame_err_pulses", frame_err_cnt - f0, 1);
        check_int("frame_err_no_push", pop_cnt - p0, 0);
        exp_q.push_back(8'h3C);
        @(posedge clk); #1;
        send_frame(8'h3C, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_int("frame_err_recovery", pop_cnt - p0, 1);
        check_int("frame_err_once", frame_err_cnt - f0, 1);
    endtask

    task automatic test_reset_mid_frame();
        int p0, e0;
        logic [7:0] d;
        bus.rx_ready_i = 1'b0;
        @(posedge clk); #1;
        send_frame(8'h11, 1'b1, 1'b0);
        d = 8'h22;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx_i = d[4];
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx_i  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_int("midreset_valid", int'(bus.rx_valid_o), 0);
        p0 = pop_cnt;
        e0 = frame_err_cnt + overrun_cnt + parity_err_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1 bus.rx_ready_i = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_int("midreset_fifo_flushed", pop_cnt - p0, 0);
        check_int("midreset_errors", frame_err_cnt + overrun_cnt + parity_err_cnt - e0, 0);
        exp_q.push_back(8'h81);
        @(posedge clk); #1;
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_int("midreset_next_frame", pop_cnt - p0, 1);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int p0, q0, f0;
        p0 = pop_cnt;
        q0 = parity_err_cnt;
        f0 = frame_err_cnt;
        bus.rx_ready_i = 1'b1;
        @(posedge clk); #1;
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_int("parity_err_pulses", parity_err_cnt - q0, 1);
        check_int("parity_err_no_push", pop_cnt - p0, 0);
        check_int("parity_no_frame_err", frame_err_cnt - f0, 0);
        exp_q.push_back(8'h07);
        @(posedge clk); #1;
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_int("parity_good_pops", pop_cnt - p0, 1);
        check_int("parity_good_no_err", parity_err_cnt - q0, 1);
    endtask
`endif

    initial begin
        bus.rx_ready_i = 1'b0;
        test_reset();
        test_single_byte();
        test_overrun();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_int("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
